// File: rtl/uart_rx_os16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_rx_os16                                                   |
// | Brief   : 16x-oversampling UART receiver, 8N1 by default; 8E1 when the   |
// |           UART_RX_PARITY_EN macro is defined. Mid-bit sampling, start    |
// |           glitch rejection, framing and parity error strobes.            |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module uart_rx_os16 #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] doutrx,
    output logic       donerx,
    output logic       ferr,
    output logic       perr,
    output logic       busy
);

    localparam int c_div    = clk_freq / (16 * baud_rate);
    localparam int c_tick_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_tick_w-1:0] c_tick_max = c_tick_w'(c_div - 1);
    localparam logic [c_tick_w-1:0] c_tick_one = c_tick_w'(1);

    if (c_div < 1) begin : g_div_check
        $error("uart_rx_os16: clk_freq/(16*baud_rate) must be at least 1");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t              r_state;
    logic                r_rx_meta;
    logic                r_rx_sync;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [3:0]          r_os;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic [7:0]          r_dout;
    logic                r_done;
    logic                r_ferr;
    logic                r_busy;
    logic                w_tick;
    logic                w_sample;
    logic                w_start_det;
    logic                w_par_bad;

    // Both flops reset high so an idle line is not mistaken for a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_tick      = (r_tick_cnt == c_tick_max);
    assign w_sample    = w_tick && (r_os == 4'd7);
    assign w_start_det = (r_state == S_IDLE) && !r_rx_sync;

    // Restarting the tick phase on the start edge puts sample 8 ticks later at mid-bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
            r_os       <= 4'd0;
        end else if (w_start_det) begin
            r_tick_cnt <= '0;
            r_os       <= 4'd0;
        end else begin
            if (w_tick) begin
                r_tick_cnt <= '0;
                r_os       <= r_os + 4'd1;
            end else begin
                r_tick_cnt <= r_tick_cnt + c_tick_one;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_perr;

    assign w_par_bad = ^{r_shift, r_par_bit};
    assign perr      = r_perr;
`else
    assign w_par_bad = 1'b0;
    assign perr      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_dout    <= 8'h00;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_start_det) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_sample) begin
                        if (!r_rx_sync) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_sample) begin
                        r_par_bit <= r_rx_sync;
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // Leaving at mid-stop lets a back-to-back start bit be caught
                    if (w_sample) begin
                        if (r_rx_sync && !w_par_bad) begin
                            r_dout <= r_shift;
                            r_done <= 1'b1;
                        end
                        r_ferr <= !r_rx_sync;
`ifdef UART_RX_PARITY_EN
                        r_perr <= w_par_bad;
`endif
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign doutrx = r_dout;
    assign donerx = r_done;
    assign ferr   = r_ferr;
    assign busy   = r_busy;

endmodule
`default_nettype wire
